// File: rtl/cpu_pkg.sv
// Shared types and default sizing for the 8-bit core's load/store path.
package cpu_pkg;

    // Default data width, address width and memory wait cycles.
    localparam int unsigned CPU_DW  = 8;
    localparam int unsigned CPU_AW  = 8;
    localparam int unsigned CPU_LAT = 2;

    // Wait-state counter width; covers the legal latency range 1..15.
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        WB
    } mau_state_t;

endpackage

// File: rtl/data_mem.sv
// Data memory: synchronous write, asynchronous read, no reset of contents.
module data_mem #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    localparam int unsigned Depth = 2 ** AW;

    logic [DW-1:0] mem [Depth];

    // Write port; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    // Asynchronous read of the addressed word.
    always_comb begin
        rdata_o = mem[addr_i];
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: latches a request, waits LAT cycles on the data
// memory, then retires a store directly or a load through a one-cycle WB state.
module mem_access_unit
    import cpu_pkg::*;
#(
    parameter int unsigned DW  = CPU_DW,
    parameter int unsigned AW  = CPU_AW,
    parameter int unsigned LAT = CPU_LAT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          is_load,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          rf_wr_en,
    output logic          stall,
    output logic          done
);

    localparam logic [CNT_W-1:0] CntInit = CNT_W'(LAT - 1);

    mau_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             is_load_q, is_load_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             rf_wr_en_q, rf_wr_en_d;
    logic             done_q, done_d;

    logic             mem_we;
    logic             mem_we_gated;
    logic [DW-1:0]    mem_rdata;

    // Reset must also cancel a store whose write would land on this edge.
    assign mem_we_gated = mem_we & ~reset;

    data_mem #(
        .DW(DW),
        .AW(AW)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we_gated),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    // Next-state, request latching and retirement strobes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_load_d  = is_load_q;
        rdata_d    = rdata_q;
        rf_wr_en_d = 1'b0;
        done_d     = 1'b0;
        mem_we     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d    = addr;
                    wdata_d   = wdata;
                    is_load_d = is_load;
                    cnt_d     = CntInit;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (is_load_q) begin
                    rdata_d    = mem_rdata;
                    rf_wr_en_d = 1'b1;
                    done_d     = 1'b1;
                    state_d    = WB;
                end else begin
                    mem_we  = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            WB: begin
                // A start seen here is ignored; it is taken next cycle in IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_load_q  <= 1'b0;
            rdata_q    <= '0;
            rf_wr_en_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_load_q  <= is_load_d;
            rdata_q    <= rdata_d;
            rf_wr_en_q <= rf_wr_en_d;
            done_q     <= done_d;
        end
    end

    // Stall is combinational so the requesting instruction holds in its own cycle.
    always_comb begin
        stall    = ((state_q == IDLE) && start) || (state_q == WAIT);
        rdata    = rdata_q;
        rf_wr_en = rf_wr_en_q;
        done     = done_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a LAT=2 and a LAT=1 instance share inputs.
module tb_mem_access_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       is_load;
    logic [7:0] addr;
    logic [7:0] wdata;

    logic [7:0] rdata0, rdata1;
    logic       wr0, wr1, stall0, stall1, done0, done1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_unit #(
        .DW  (8),
        .AW  (8),
        .LAT (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .is_load  (is_load),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata0),
        .rf_wr_en (wr0),
        .stall    (stall0),
        .done     (done0)
    );

    mem_access_unit #(
        .DW  (8),
        .AW  (8),
        .LAT (1)
    ) dut1 (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .is_load  (is_load),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata1),
        .rf_wr_en (wr1),
        .stall    (stall1),
        .done     (done1)
    );

    typedef struct {
        bit         sel1;   // 1 = check the LAT=1 instance
        logic       ld;
        logic [7:0] a;
        logic [7:0] wd;
        bit         pre_en;
        logic [7:0] pre;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] v);
        dut.u_mem.mem[a]  = v;
        dut1.u_mem.mem[a] = v;
    endtask

    function automatic logic [7:0] peek(input bit sel1, input logic [7:0] a);
        return sel1 ? dut1.u_mem.mem[a] : dut.u_mem.mem[a];
    endfunction

    // One access with start held only in the request cycle; tallies strobes per cycle.
    task automatic run_access(input bit sel1, input logic ld, input logic [7:0] a,
                              input logic [7:0] wd, input logic [7:0] exp_rd,
                              input string nm);
        int         lat      = sel1 ? 1 : 2;
        int         stall_n  = 0;
        int         wr_n     = 0;
        int         done_n   = 0;
        int         wr_cyc   = -1;
        int         done_cyc = -1;
        logic [7:0] rd_seen  = 8'h00;
        start   = 1'b1;
        is_load = ld;
        addr    = a;
        wdata   = wd;
        #1;
        if ((sel1 ? stall1 : stall0) === 1'b1) stall_n++;
        for (int c = 1; c <= lat + 4; c++) begin
            tick();
            start = 1'b0;
            #1;
            if ((sel1 ? stall1 : stall0) === 1'b1) stall_n++;
            if ((sel1 ? wr1 : wr0) === 1'b1) begin
                wr_n++;
                wr_cyc  = c;
                rd_seen = sel1 ? rdata1 : rdata0;
            end
            if ((sel1 ? done1 : done0) === 1'b1) begin
                done_n++;
                done_cyc = c;
            end
        end
        chk({nm, "_stall_cycles"}, 32'(stall_n), 32'(lat + 1));
        chk({nm, "_done_count"}, 32'(done_n), 32'd1);
        chk({nm, "_done_cycle"}, 32'(done_cyc), 32'(lat + 1));
        if (ld) begin
            chk({nm, "_wr_count"}, 32'(wr_n), 32'd1);
            chk({nm, "_wr_cycle"}, 32'(wr_cyc), 32'(lat + 1));
            chk({nm, "_rdata"}, 32'(rd_seen), 32'(exp_rd));
        end else begin
            chk({nm, "_wr_count"}, 32'(wr_n), 32'd0);
            chk({nm, "_mem"}, 32'(peek(sel1, a)), 32'(wd));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_n;
        int done_n;
        int stall_n;

        vecs[0] = '{1'b0, 1'b1, 8'h10, 8'h00, 1'b1, 8'hA5, 8'hA5};
        vecs[1] = '{1'b0, 1'b0, 8'h20, 8'h3C, 1'b1, 8'h00, 8'h00};
        vecs[2] = '{1'b0, 1'b1, 8'h20, 8'h00, 1'b0, 8'h00, 8'h3C};
        vecs[3] = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 8'h5A, 8'h5A};
        vecs[4] = '{1'b1, 1'b0, 8'h00, 8'hC3, 1'b1, 8'h77, 8'h00};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 8'hC3};
        vecs[6] = '{1'b0, 1'b1, 8'h7F, 8'h00, 1'b1, 8'h00, 8'h00};

        for (int i = 0; i < 256; i++) poke(8'(i), 8'h00);

        // Reset with start held high: reset wins, nothing is accepted.
        reset   = 1'b1;
        start   = 1'b1;
        is_load = 1'b1;
        addr    = 8'h10;
        wdata   = 8'h00;
        tick();
        tick();
        tick();
        chk("rst_rdata0", 32'(rdata0), 32'h0);
        chk("rst_wr0", 32'(wr0), 32'h0);
        chk("rst_done0", 32'(done0), 32'h0);
        chk("rst_wr1", 32'(wr1), 32'h0);
        chk("rst_done1", 32'(done1), 32'h0);
        chk("rst_stall_follows_start", 32'(stall0), 32'h1);
        reset = 1'b0;
        start = 1'b0;
        #1;
        chk("rst_idle_stall0", 32'(stall0), 32'h0);
        chk("rst_idle_stall1", 32'(stall1), 32'h0);
        tick();

        // Table of single accesses.
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].pre_en) poke(vecs[i].a, vecs[i].pre);
            run_access(vecs[i].sel1, vecs[i].ld, vecs[i].a, vecs[i].wd, vecs[i].exp_rd,
                       $sformatf("v%0d", i));
        end

        // Start held through WAIT: exactly one load retires.
        poke(8'h50, 8'h99);
        wr_n    = 0;
        done_n  = 0;
        stall_n = 0;
        start   = 1'b1;
        is_load = 1'b1;
        addr    = 8'h50;
        #1;
        if (stall0 === 1'b1) stall_n++;
        for (int c = 1; c <= 9; c++) begin
            tick();
            start = (c < 3);
            #1;
            if (stall0 === 1'b1) stall_n++;
            if (wr0 === 1'b1) begin
                wr_n++;
                chk("hold_rdata", 32'(rdata0), 32'h99);
            end
            if (done0 === 1'b1) done_n++;
        end
        chk("hold_stall_cycles", 32'(stall_n), 32'd3);
        chk("hold_wr_count", 32'(wr_n), 32'd1);
        chk("hold_done_count", 32'(done_n), 32'd1);

        // Reset in cycle 1 of a store: memory untouched, no done.
        poke(8'h30, 8'h11);
        start   = 1'b1;
        is_load = 1'b0;
        addr    = 8'h30;
        wdata   = 8'h99;
        tick();
        start = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_st_wait_stall", 32'(stall0), 32'h1);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_st_idle_stall0", 32'(stall0), 32'h0);
        chk("rst_st_idle_stall1", 32'(stall1), 32'h0);
        done_n = 0;
        for (int c = 0; c < 5; c++) begin
            if (done0 === 1'b1 || done1 === 1'b1) done_n++;
            tick();
        end
        chk("rst_st_done_count", 32'(done_n), 32'd0);
        chk("rst_st_mem0", 32'(peek(1'b0, 8'h30)), 32'h11);
        chk("rst_st_mem1", 32'(peek(1'b1, 8'h30)), 32'h11);

        // Reset in the last WAIT cycle of a load: no write-back, no done.
        poke(8'h31, 8'h22);
        start   = 1'b1;
        is_load = 1'b1;
        addr    = 8'h31;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        wr_n   = 0;
        done_n = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (wr0 === 1'b1) wr_n++;
            if (done0 === 1'b1) done_n++;
            tick();
        end
        chk("rst_ld_wr_count", 32'(wr_n), 32'd0);
        chk("rst_ld_done_count", 32'(done_n), 32'd0);
        chk("rst_ld_rdata", 32'(rdata0), 32'h0);

        // Load, then a store requested during WB: store accepted only in IDLE.
        poke(8'h10, 8'hA5);
        poke(8'h60, 8'h00);
        start   = 1'b1;
        is_load = 1'b1;
        addr    = 8'h10;
        tick();
        start = 1'b0;
        tick();
        tick();
        start   = 1'b1;
        is_load = 1'b0;
        addr    = 8'h60;
        wdata   = 8'hEE;
        #1;
        chk("b2b_wb_wr", 32'(wr0), 32'h1);
        chk("b2b_wb_rdata", 32'(rdata0), 32'hA5);
        chk("b2b_wb_stall", 32'(stall0), 32'h0);
        tick();
        #1;
        chk("b2b_idle_stall", 32'(stall0), 32'h1);
        chk("b2b_idle_done", 32'(done0), 32'h0);
        tick();
        start = 1'b0;
        wr_n  = 0;
        #1;
        if (wr0 === 1'b1) wr_n++;
        tick();
        #1;
        if (wr0 === 1'b1) wr_n++;
        chk("b2b_mem_before", 32'(peek(1'b0, 8'h60)), 32'h00);
        chk("b2b_done_early", 32'(done0), 32'h0);
        tick();
        #1;
        if (wr0 === 1'b1) wr_n++;
        chk("b2b_mem_after", 32'(peek(1'b0, 8'h60)), 32'hEE);
        chk("b2b_store_done", 32'(done0), 32'h1);
        chk("b2b_store_wr", 32'(wr_n), 32'd0);
        tick();
        #1;
        chk("b2b_done_once", 32'(done0), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle load/store unit for the 8-bit core. It takes an address from register-file read port B and store data from read port A, and models a data memory with a fixed wait-state latency. It returns load data, with a one-cycle write strobe, to the register-file write port. While an access is in flight it holds the rest of the core with a stall signal.

## Interface
Parameters:
- DW, 8, data width (matches register-file word)
- AW, 8, memory address width; memory depth 2**AW
- LAT, 2, memory wait cycles per access; legal range 1..15

Ports:
- clk  input  1  system clock, all state on posedge
- reset  input  1  synchronous, active-high; one clock, synchronous reset
- start  input  1  access request from decode, sampled only in IDLE
- is_load  input  1  1 = load, 0 = store; sampled with start
- addr  input  AW  memory address (register-file port B data)
- wdata  input  DW  store data (register-file port A data)
- rdata  output  DW  load result to register-file write data
- rf_wr_en  output  1  one-cycle register-file write strobe for a load result
- stall  output  1  hold fetch/PC and decode
- done  output  1  one-cycle pulse when an access retires, load or store

## Operation
- FSM states: IDLE, WAIT, WB. Reset state is IDLE.
- IDLE with start=1:
  - latch addr, wdata and is_load
  - cnt <= LAT-1
  - go to WAIT
- IDLE with start=0: stay in IDLE.
- WAIT, cnt != 0: cnt <= cnt-1.
- WAIT, cnt == 0, load: rdata <= mem[latched addr]; go to WB.
- WAIT, cnt == 0, store: mem[latched addr] <= latched wdata; done pulses next cycle; go to IDLE.
- WB: rf_wr_en=1 and done=1 for this one cycle; go to IDLE.
- Outputs:
  - stall = start (in IDLE) OR state==WAIT; combinational, so the requesting instruction holds.
  - stall is low in WB, so the core advances on the same edge the register file captures rdata.
- start in WAIT or WB is ignored, with no queueing. While stall is high, decode holds start steady, so the held request is not re-accepted: the FSM leaves IDLE only once.
- Memory contents are not affected by reset; they power up undefined. The bench preloads them hierarchically.
- Address arithmetic is modulo 2**AW; there is no bounds error.

## Timing
- Reset values:
  - state=IDLE, cnt=0
  - rdata=0, rf_wr_en=0, done=0
  - stall=start (combinational)
- Load latency: accept edge E0, then LAT cycles in WAIT, then WB in cycle LAT+1. The register-file write happens on edge E0+LAT+1. Total stall cycles = LAT+1, counting the request cycle.
- Store latency: memory write on edge E0+LAT; done high for the following cycle. No rf_wr_en.
- done is registered and high for exactly one cycle per accepted access.
- Back-to-back accesses:
  - a new start in the WB cycle is not accepted until the next cycle, in IDLE
  - minimum spacing between accesses is LAT+2 cycles for loads and LAT+1 cycles for stores
- Reset mid-operation, in WAIT or WB:
  - next state is IDLE
  - a pending store is discarded, so memory is unchanged
  - a pending load produces no rf_wr_en or done
- Reset has priority over start in the same cycle.

## Structure
- Shared package cpu_pkg:
  - typedef enum logic[1:0] {IDLE, WAIT, WB} mau_state_t
  - constants DW, AW, default LAT
- One sub-module: data_mem, a 2**AW x DW array with a synchronous write enable and an asynchronous read. The FSM and counter stay in mem_access_unit.

## Test plan
- Load, LAT=2, mem[0x10]=0xA5, addr=0x10, start held 1 cycle in IDLE:
  - stall is high for 3 cycles
  - rf_wr_en and done pulse in cycle 3, with rdata=0xA5
- Store, addr=0x20, wdata=0x3C; then load from 0x20:
  - mem[0x20]=0x3C after edge E0+2
  - the following load returns 0x3C
  - rf_wr_en is never high during the store
- Start held high through WAIT, modelling decode holding the request:
  - exactly one access occurs
  - done pulses once
- Reset asserted in cycle 1 of a store to 0x30, with mem[0x30]=0x11:
  - FSM is in IDLE next cycle
  - mem[0x30] is still 0x11
  - no done pulse
- LAT=1 build, load from 0xFF:
  - WB in cycle 2
  - stall is high 2 cycles
  - address 0xFF reads correctly at the top boundary
- Load followed immediately by a store request during the WB cycle:
  - the store is accepted in the next IDLE cycle, not in WB
  - the load's rf_wr_en is unaffected
